// File: rtl/parking_slot_controller.sv
// Parking-lot occupancy sequencer: arbitrates entry/exit requests and drives a 3-bit adder/subtractor.
// Optional macro SUM_CHECK_EN adds a sticky sum_fault output that checks the adder carry/no-borrow bit.

module adder_subtractor_3bit (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       s_i,
  output logic [3:0] sum_o
);
  // S=1 subtracts via two's complement: A + ~B + 1; sum_o[3] is carry / no-borrow.
  logic [2:0] b_x;
  assign b_x   = b_i ^ {3{s_i}};
  assign sum_o = {1'b0, a_i} + {1'b0, b_x} + {3'b000, s_i};
endmodule

module parking_slot_controller #(
  parameter int unsigned CAPACITY    = 7,
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_deny,
  output logic       exit_deny,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
`ifdef SUM_CHECK_EN
  ,
  output logic       sum_fault
`endif
);

  localparam int unsigned CW = 3;
  localparam int unsigned GW = 8;
  localparam logic [CW-1:0] CAP_C      = CW'(CAPACITY);
  localparam logic [GW-1:0] GATE_LOAD  = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    GATE    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;        // 0 = entry served, 1 = exit served
  logic          rr_q, rr_d;          // 0 = entry wins next contested pick
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          entry_ack_q, entry_ack_d;
  logic          exit_ack_q, exit_ack_d;
  logic          entry_deny_q, entry_deny_d;
  logic          exit_deny_q, exit_deny_d;
  logic          entry_gate_q, entry_gate_d;
  logic          exit_gate_q, exit_gate_d;

  logic [CW-1:0] add_b;
  logic          add_s;
  logic [3:0]    sum;
  logic          pick_exit;
  logic          served_req;
  logic          full_w;
  logic          empty_w;

  adder_subtractor_3bit u_addsub (
    .a_i   (count_q),
    .b_i   (add_b),
    .s_i   (add_s),
    .sum_o (sum)
  );

  assign full_w     = (count_q == CAP_C);
  assign empty_w    = (count_q == 3'd0);
  assign pick_exit  = (entry_req && exit_req) ? rr_q : exit_req;
  assign served_req = sel_q ? exit_req : entry_req;

  // Adder operands depend only on registered state, keeping them off the next-state path.
  always_comb begin
    add_b = 3'b000;
    add_s = 1'b0;
    if (state_q == CALC) begin
      add_b = 3'b001;
      add_s = sel_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    count_d      = count_q;
    gcnt_d       = gcnt_q;
    entry_ack_d  = 1'b0;
    exit_ack_d   = 1'b0;
    entry_deny_d = 1'b0;
    exit_deny_d  = 1'b0;
    entry_gate_d = entry_gate_q;
    exit_gate_d  = exit_gate_q;
    unique case (state_q)
      IDLE: begin
        if (entry_req || exit_req) begin
          sel_d = pick_exit;
          if (entry_req && exit_req) rr_d = ~rr_q;
          if (!pick_exit && full_w) begin
            entry_deny_d = 1'b1;
            state_d      = RELEASE;
          end else if (pick_exit && empty_w) begin
            exit_deny_d = 1'b1;
            state_d     = RELEASE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        count_d      = sum[2:0];
        gcnt_d       = GATE_LOAD;
        entry_ack_d  = ~sel_q;
        exit_ack_d   = sel_q;
        entry_gate_d = ~sel_q;
        exit_gate_d  = sel_q;
        state_d      = GATE;
      end
      GATE: begin
        if (gcnt_q == '0) begin
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
          state_d      = RELEASE;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      RELEASE: begin
        if (!served_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      rr_q         <= 1'b0;
      count_q      <= '0;
      gcnt_q       <= '0;
      entry_ack_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      entry_deny_q <= 1'b0;
      exit_deny_q  <= 1'b0;
      entry_gate_q <= 1'b0;
      exit_gate_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      count_q      <= count_d;
      gcnt_q       <= gcnt_d;
      entry_ack_q  <= entry_ack_d;
      exit_ack_q   <= exit_ack_d;
      entry_deny_q <= entry_deny_d;
      exit_deny_q  <= exit_deny_d;
      entry_gate_q <= entry_gate_d;
      exit_gate_q  <= exit_gate_d;
    end
  end

`ifdef SUM_CHECK_EN
  // Increment must not carry; decrement must report no-borrow.
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (state_q == CALC && sum[3] != sel_q) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign sum_fault = fault_q;
`else
  logic sum_carry_unused;
  assign sum_carry_unused = sum[3];
`endif

  assign entry_ack  = entry_ack_q;
  assign exit_ack   = exit_ack_q;
  assign entry_deny = entry_deny_q;
  assign exit_deny  = exit_deny_q;
  assign entry_gate = entry_gate_q;
  assign exit_gate  = exit_gate_q;
  assign count      = count_q;
  assign full       = full_w;
  assign empty      = empty_w;

endmodule
